// File: rtl/mem_responder_pkg.sv
// Shared definitions for the wait-stated M-bus memory responder:
// FSM encoding, default widths and the wait-state counter bounds.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int ADDR_W_DEF   = 8;
  localparam int WAIT_CYC_MIN = 1;
  localparam int WAIT_CYC_MAX = 15;
  localparam int CNT_W        = $clog2(WAIT_CYC_MAX + 1);

endpackage

// File: rtl/mem_responder_array.sv
// Single-port storage: synchronous write, registered read with a resettable
// output register so the read port can drive the M-bus directly.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// M-bus memory responder: accepts one read or write in IDLE, inserts WAIT_CYC
// wait states, performs the access, then pulses MEM_ready for one cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_CYC = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_to_M,
  input  logic              MRD,
  input  logic              MWR,
  output logic [DATA_W-1:0] MEM_to_M,
  output logic              MEM_ready,
  output logic              MEM_busy,
  output logic              MEM_err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               wr_op_q, wr_op_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               mem_we, mem_re;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_op_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_op_q <= wr_op_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_op_d = wr_op_q;
    case (state_q)
      ST_IDLE: begin
        if (MRD ^ MWR) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_CYC);
          addr_d  = MAR_addr;
          data_d  = MDR_to_M;
          wr_op_d = MWR;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every pin comes from a flop.
  // CLR masks the array strobes so an access cut by reset has no effect.
  always_comb begin
    ready_d = (state_d == ST_ACK);
    busy_d  = (state_d != ST_IDLE);
    err_d   = (state_q == ST_IDLE) && MRD && MWR;
    mem_we  = (state_q == ST_ACCESS) && wr_op_q && !CLR;
    mem_re  = (state_q == ST_ACCESS) && !wr_op_q && !CLR;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk_i   (CLK),
    .srst_i  (CLR),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (MEM_to_M)
  );

  assign MEM_ready = ready_q;
  assign MEM_busy  = busy_q;
  assign MEM_err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, M-bus data width.
REQ-002 SHALL have parameter ADDR_W, default 8, word address width (2**ADDR_W words).
REQ-003 SHALL have parameter WAIT_CYC, default 2, wait-state count; legal range 1..15.
REQ-004 SHALL have port CLK  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port CLR  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port MAR_addr  input  ADDR_W  word address presented with a request.
REQ-007 SHALL have port MDR_to_M  input  DATA_W  write data driven by the MDR onto the M-bus.
REQ-008 SHALL have port MRD  input  1  read request, level, sampled only in IDLE.
REQ-009 SHALL have port MWR  input  1  write request, level, sampled only in IDLE.
REQ-010 SHALL have port MEM_to_M  output  DATA_W  read data returned on the M-bus toward MDR (MMD path).
REQ-011 SHALL have port MEM_ready  output  1  one-cycle completion pulse for an accepted read or write.
REQ-012 SHALL have port MEM_busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port MEM_err  output  1  one-cycle pulse on an illegal request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCESS, ACK.
REQ-015 In IDLE, exactly one of MRD/MWR high at an edge SHALL accept the request: latch MAR_addr, MDR_to_M and the op, load the wait counter with WAIT_CYC, and go to WAIT.
REQ-016 In IDLE, MRD and MWR both high at an edge SHALL leave the FSM in IDLE, latch nothing, and pulse MEM_err for the following cycle.
REQ-017 WAIT SHALL decrement the counter each edge and go to ACCESS on the edge where the counter equals 1, so WAIT lasts exactly WAIT_CYC cycles.
REQ-018 ACCESS SHALL last one cycle; at its closing edge a write stores the latched data at the latched address, and a read registers the array word into MEM_to_M.
REQ-019 ACK SHALL last one cycle with MEM_ready=1, then return to IDLE.
REQ-020 MEM_ready SHALL rise WAIT_CYC+1 edges after the accepting edge and last exactly one cycle.
REQ-021 MRD/MWR changes while MEM_busy=1 SHALL be ignored; nothing is queued.
REQ-022 MEM_to_M SHALL hold the last read value until the next completed read; writes SHALL NOT change it.
REQ-023 A read of an address written by the immediately preceding write SHALL return the new data.
REQ-024 Address arithmetic SHALL be modulo 2**ADDR_W; no out-of-range condition exists.
REQ-025 A request held high through ACK SHALL be accepted again on the first IDLE edge (back-to-back access, one IDLE cycle between ACK and the new WAIT).

Reset
REQ-026 CLR=1 at an edge SHALL force IDLE, counter 0, MEM_to_M=0, MEM_ready=0, MEM_busy=0, MEM_err=0.
REQ-027 CLR during WAIT or ACCESS SHALL abort the operation; a write aborted before its ACCESS closing edge SHALL NOT modify the array.
REQ-028 Reset SHALL NOT clear array contents; contents after power-up are undefined.
REQ-029 CLR SHALL take priority over any simultaneous MRD/MWR.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, DATA_W/ADDR_W defaults and the WAIT_CYC bound.
REQ-031 Storage SHALL be a sub-module mem_array (single-port, synchronous write, registered read) instantiated once.
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 Reset, MWR=1 with MAR_addr=0x12 and MDR_to_M=0x00A5 for one cycle -> MEM_busy=1 for 4 cycles, MEM_ready pulses 3 edges later, MEM_to_M stays 0x0000.
REQ-034 After REQ-033, MRD with MAR_addr=0x12 -> MEM_ready after 3 edges, MEM_to_M=0x00A5 and held while idle.
REQ-035 MRD=MWR=1 in IDLE -> MEM_err pulses 1 cycle, MEM_busy stays 0, array and MEM_to_M unchanged.
REQ-036 MWR to 0x34 with data 0x1111, CLR pulsed in WAIT, then read 0x34 -> old contents of 0x34 returned, not 0x1111.
REQ-037 Write 0xFF=0xBEEF, MRD held high through ACK to 0xFF -> second access accepted after one IDLE cycle, MEM_to_M=0xBEEF.
REQ-038 WAIT_CYC=1 and WAIT_CYC=15 builds -> MEM_ready at 2 and 16 edges after acceptance respectively.
